// File: rtl/bus_slave_ram_pkg.sv
// -----------------------------------------------------------------------------
// bus_slave_ram_pkg
//   Shared definitions for the bus slave RAM: bus direction encodings, bus
//   widths, wait-counter width and the slave FSM state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package bus_slave_ram_pkg;

  localparam int WORD_ADDR_W = 30;   // CPU word-address bus width
  localparam int WORD_DATA_W = 32;   // CPU word-data bus width
  localparam int WAIT_CNT_W  = 4;    // wait-state counter, covers 0..15

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/slave_spram.sv
// -----------------------------------------------------------------------------
// slave_spram
//   Single-port synchronous RAM with a one-cycle registered read, written so
//   that it maps onto a block RAM.
// Ports
//   clk      in   clock, rising edge
//   en       in   access enable for this edge
//   we       in   1 = write wr_data to addr, 0 = read addr into rd_data
//   addr     in   word address
//   wr_data  in   write data
//   rd_data  out  registered read data, holds its value between reads
// -----------------------------------------------------------------------------
module slave_spram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array and its read register have no reset; a reset port here
  // would stop the tools from mapping the array onto a block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wr_data;
      else    rd_data   <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_slave_ram.sv
// -----------------------------------------------------------------------------
// bus_slave_ram
//   Memory-mapped bus slave in front of a word-addressed single-port RAM.
//   Accepts one transaction per request strobe, inserts WAIT_CYCLES wait
//   states, then acknowledges for exactly one cycle with Rdy_ low. The master
//   may abort during the wait phase by releasing Cs_ or As_.
// Ports
//   clk      in   clock, rising edge
//   reset_   in   asynchronous active-low reset
//   Cs_      in   chip select from the address decoder, active low
//   As_      in   address strobe from the master, active low
//   RW       in   1 = read, 0 = write
//   Addr     in   word address; bits above ADDR_W alias
//   WrData   in   write data, valid together with As_
//   RdData   out  read data during a read acknowledge, zero otherwise
//   Rdy_     out  acknowledge, active low, one cycle per transaction
// -----------------------------------------------------------------------------
module bus_slave_ram
  import bus_slave_ram_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   Cs_,
  input  logic                   As_,
  input  logic                   RW,
  input  logic [WORD_ADDR_W-1:0] Addr,
  input  logic [WORD_DATA_W-1:0] WrData,
  output logic [WORD_DATA_W-1:0] RdData,
  output logic                   Rdy_
);

  // Counter preload: WAIT_CYCLES wait states means WAIT_CYCLES-1 decrements
  // after the first WAIT cycle.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t                  state, state_d;
  logic [WAIT_CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]       addr_q;
  logic                    rw_q;
  logic [WORD_DATA_W-1:0]  wdata_q;
  logic                    rd_sel;

  logic                    req;
  logic                    enter_ack;
  logic                    use_live;
  logic                    ram_en;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [WORD_DATA_W-1:0]  ram_wdata;
  logic [WORD_DATA_W-1:0]  ram_rdata;
  logic                    unused_addr_bits;

  assign req = !Cs_ && !As_;

  // NOTE: every output of this block is given a default first so that no
  // path through the case statement leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (req) state_d = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT: begin
        if (!req)            state_d = ST_IDLE;   // master abort
        else if (cnt == '0)  state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;                 // As_ still low here is not a new request
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_ack = (state_d == ST_ACK);

  // With zero wait states the RAM is accessed on the same edge that samples
  // the request, before the latches hold it, so take the live bus in IDLE.
  assign use_live  = (state == ST_IDLE);
  assign ram_addr  = use_live ? Addr[ADDR_W-1:0] : addr_q;
  assign ram_wdata = use_live ? WrData : wdata_q;
  assign ram_we    = ((use_live ? RW : rw_q) == WRITE);
  // Gated by reset_ so a request held on the bus during reset cannot write.
  assign ram_en    = enter_ack && reset_;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      Rdy_    <= 1'b1;
      rd_sel  <= 1'b0;
    end else begin
      state <= state_d;
      if (state == ST_IDLE && req) begin
        addr_q  <= Addr[ADDR_W-1:0];
        rw_q    <= RW;
        wdata_q <= WrData;
        cnt     <= WAIT_LOAD;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - WAIT_CNT_W'(1);
      end
      Rdy_   <= !enter_ack;
      rd_sel <= enter_ack && !ram_we;
    end
  end

  // RAM output register is only exposed during a read acknowledge; zero
  // otherwise so the slave can sit on an OR-combined read bus.
  assign RdData = rd_sel ? ram_rdata : '0;

  // Upper address bits alias by design.
  assign unused_addr_bits = ^Addr[WORD_ADDR_W-1:ADDR_W];

  slave_spram #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_DATA_W)
  ) u_ram (
    .clk     (clk),
    .en      (ram_en),
    .we      (ram_we),
    .addr    (ram_addr),
    .wr_data (ram_wdata),
    .rd_data (ram_rdata)
  );

endmodule

// File: tb/tb_bus_slave_ram.sv
// -----------------------------------------------------------------------------
// tb_bus_slave_ram
//   Directed bench for bus_slave_ram. Three instances share clock and reset:
//   index 0 has no wait states, index 1 one wait state, index 2 three.
// -----------------------------------------------------------------------------
module tb_bus_slave_ram;
  import bus_slave_ram_pkg::*;

  logic        clk = 1'b0;
  logic        reset_;
  logic [2:0]  cs;
  logic [2:0]  as;
  logic [2:0]  rw;
  logic [2:0]  rdy;
  logic [29:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rd    [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_slave_ram #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_(reset_), .Cs_(cs[0]), .As_(as[0]), .RW(rw[0]),
    .Addr(addr[0]), .WrData(wdata[0]), .RdData(rd[0]), .Rdy_(rdy[0]));
  bus_slave_ram #(.ADDR_W(10), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset_(reset_), .Cs_(cs[1]), .As_(as[1]), .RW(rw[1]),
    .Addr(addr[1]), .WrData(wdata[1]), .RdData(rd[1]), .Rdy_(rdy[1]));
  bus_slave_ram #(.ADDR_W(10), .WAIT_CYCLES(3)) dut2 (
    .clk(clk), .reset_(reset_), .Cs_(cs[2]), .As_(as[2]), .RW(rw[2]),
    .Addr(addr[2]), .WrData(wdata[2]), .RdData(rd[2]), .Rdy_(rdy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One full transaction on instance d. exp_lat counts negedge samples from
  // the drive point (the first sample precedes the request edge), so a slave
  // with W wait states acknowledges at sample W+2.
  task automatic txn(input int d, input logic dir, input logic [29:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd,
                     input int exp_lat, input string tag);
    int          lat;
    logic [31:0] got;
    lat = 0;
    got = 32'hxxxx_xxxx;
    @(posedge clk); #1;
    cs[d] = 1'b0; as[d] = 1'b0; rw[d] = dir; addr[d] = a; wdata[d] = wd;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (!rdy[d]) begin
        lat = i;
        got = rd[d];
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, got, exp_rd);
    @(posedge clk); #1;              // master drops the strobe on the Rdy_ edge
    cs[d] = 1'b1; as[d] = 1'b1;
    @(negedge clk);
    check({tag, "_rdy_one_cycle"}, 32'(rdy[d]), 32'd1);
    check({tag, "_data_idle"}, rd[d], 32'h0);
  endtask

  initial begin
    int lows;
    cs = '1; as = '1; rw = '1;
    for (int i = 0; i < 3; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
    end
    reset_ = 1'b1;
    #1 reset_ = 1'b0;
    #1;
    check("reset_rdy", 32'(rdy), 32'h7);
    check("reset_rd0", rd[0], 32'h0);
    check("reset_rd2", rd[2], 32'h0);
    #10 reset_ = 1'b1;

    // Reset during WAIT discards the pending write.
    txn(1, WRITE, 30'h004, 32'h1111_2222, 32'h0, 3, "t1_seed");
    @(posedge clk); #1;
    cs[1] = 1'b0; as[1] = 1'b0; rw[1] = WRITE; addr[1] = 30'h004; wdata[1] = 32'h9999_9999;
    @(posedge clk);                  // request sampled, slave now in WAIT
    #3 reset_ = 1'b0;
    cs[1] = 1'b1; as[1] = 1'b1;
    #1;
    check("t1_reset_rdy", 32'(rdy[1]), 32'd1);
    check("t1_reset_rd", rd[1], 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_ = 1'b1;
    txn(1, READ, 30'h004, 32'h0, 32'h1111_2222, 3, "t1_readback");

    // One wait state: write then read back.
    txn(1, WRITE, 30'h010, 32'hDEAD_BEEF, 32'h0, 3, "t2_wr");
    txn(1, READ,  30'h010, 32'h0, 32'hDEAD_BEEF, 3, "t2_rd");

    // Zero wait states, back-to-back master with As_ held low through ACK.
    @(posedge clk); #1;
    cs[0] = 1'b0; as[0] = 1'b0; rw[0] = WRITE; addr[0] = 30'h3FF; wdata[0] = 32'h1;
    @(negedge clk);
    check("t3_pre", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    check("t3_wr_ack", 32'(rdy[0]), 32'd0);
    check("t3_wr_data", rd[0], 32'h0);
    @(posedge clk); #1;
    rw[0] = READ; wdata[0] = 32'h0;
    @(negedge clk);
    check("t3_turnaround", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    check("t3_rd_ack", 32'(rdy[0]), 32'd0);
    check("t3_rd_data", rd[0], 32'h0000_0001);
    @(posedge clk); #1;
    cs[0] = 1'b1; as[0] = 1'b1;
    @(negedge clk);
    check("t3_end", 32'(rdy[0]), 32'd1);

    // Asynchronous reset during an ACK clears the registered outputs at once.
    @(posedge clk); #1;
    cs[0] = 1'b0; as[0] = 1'b0; rw[0] = READ; addr[0] = 30'h3FF;
    @(posedge clk);
    @(negedge clk);
    check("t1b_ack_data", rd[0], 32'h0000_0001);
    #1 reset_ = 1'b0;
    cs[0] = 1'b1; as[0] = 1'b1;
    #1;
    check("t1b_reset_rdy", 32'(rdy[0]), 32'd1);
    check("t1b_reset_rd", rd[0], 32'h0);
    @(posedge clk);
    @(negedge clk) reset_ = 1'b1;

    // Abort a three-wait-state read after one wait cycle.
    lows = 0;
    @(posedge clk); #1;
    cs[2] = 1'b0; as[2] = 1'b0; rw[2] = READ; addr[2] = 30'h020;
    @(negedge clk); if (!rdy[2]) lows++;
    @(posedge clk);
    @(negedge clk); if (!rdy[2]) lows++;
    @(posedge clk); #1;
    as[2] = 1'b1;
    repeat (6) begin
      @(negedge clk); if (!rdy[2]) lows++;
    end
    cs[2] = 1'b1;
    check("t4_abort_no_rdy", 32'(lows), 32'd0);
    txn(2, WRITE, 30'h020, 32'h5, 32'h0, 5, "t4_wr");
    txn(2, READ,  30'h020, 32'h0, 32'h5, 5, "t4_rd");

    // Strobe without chip select is ignored.
    lows = 0;
    @(posedge clk); #1;
    cs[1] = 1'b1; as[1] = 1'b0; rw[1] = WRITE; addr[1] = 30'h010; wdata[1] = 32'h0BAD_0BAD;
    repeat (10) begin
      @(negedge clk); if (!rdy[1]) lows++;
    end
    as[1] = 1'b1;
    check("t5_no_rdy", 32'(lows), 32'd0);
    txn(1, READ, 30'h010, 32'h0, 32'hDEAD_BEEF, 3, "t5_ram_intact");

    // Address aliasing above 2**ADDR_W.
    txn(1, WRITE, 30'h401, 32'hA5A5_A5A5, 32'h0, 3, "t6_wr");
    txn(1, READ,  30'h001, 32'h0, 32'hA5A5_A5A5, 3, "t6_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
